hkspi_host: RTL and testbench

- Synthesizable SPI host that drives the housekeeping SPI slave pins (SCK/CSB/SDI in, SDO out) from a byte-command interface.
- Sits directly upstream of the housekeeping SPI. Used in the board-controller FPGA and as a reusable bench driver, replacing hand-written SCK/SDI task sequences.
- Executes start-CSB, end-CSB, write-byte and read/write-byte commands in SPI mode 0, MSB first. This covers normal register streams (0x40 read stream) and pass-thru sessions (0xC4 followed by flash commands).

---
 rtl/hkspi_host_pkg.sv | 28 ++
 rtl/hkspi_sync2.sv | 30 +++
 rtl/hkspi_host.sv | 224 ++++++++++++++++++++++
 tb/tb_hkspi_host.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_host_pkg.sv
// hkspi_host_pkg
// Shared definitions for the housekeeping SPI host:
//   - command opcodes presented on cmd_op
//   - host FSM state encoding
//   - housekeeping SPI command bytes used when building transactions
package hkspi_host_pkg;

    // cmd_op encodings
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_END   = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_XFER  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP_W,
        SHIFT_LO,
        SHIFT_HI,
        CS_HOLD_W,
        RESP
    } state_e;

    // Housekeeping SPI command bytes
    localparam logic [7:0] HK_RD_STREAM = 8'h40;
    localparam logic [7:0] HK_WR_STREAM = 8'h80;
    localparam logic [7:0] HK_PASSTHRU  = 8'hC4;

endpackage

// File: rtl/hkspi_sync2.sv
// hkspi_sync2
// Two-flop synchronizer that brings the asynchronous slave SDO into the
// host clock domain.
//   clock  in  system clock
//   reset  in  synchronous active-high reset (output resets to 0)
//   d      in  asynchronous input
//   q      out synchronized output, two cycles of latency
module hkspi_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/hkspi_host.sv
// hkspi_host
// SPI mode-0, MSB-first host driving the housekeeping SPI slave pins from a
// byte-command interface (START / END / WRITE / XFER).
//   clock, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_op, cmd_data      opcode and byte to shift out
//   rsp_valid             one-cycle completion pulse
//   rsp_data, rsp_err     captured byte (XFER only) and illegal-command flag
//   busy, cs_active       FSM not idle, chip select currently asserted
//   spi_sck/csb/sdi       registered pins to the slave
//   spi_sdo               slave data out, asynchronous
module hkspi_host #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       cs_active,
    output logic       spi_sck,
    output logic       spi_csb,
    output logic       spi_sdi,
    input  logic       spi_sdo
);

    import hkspi_host_pkg::*;

    localparam logic [7:0] DIV_RELOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_RELOAD = 8'(CS_SETUP - 1);

    state_e     state_q, state_d;
    logic [7:0] phase_cnt_q, phase_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] op_q, op_d;
    logic       sck_q, sck_d;
    logic       csb_q, csb_d;
    logic       sdi_q, sdi_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q, busy_d;
    logic       sdo_sync;

    hkspi_sync2 u_sdo_sync (
        .clock (clock),
        .reset (reset),
        .d     (spi_sdo),
        .q     (sdo_sync)
    );

    // The shift register serves both directions: the MSB drives SDI and the
    // synchronized SDO enters at the LSB on each SCK rise, so after eight
    // bits it holds the received byte.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        op_d        = op_q;
        sck_d       = sck_q;
        csb_d       = csb_q;
        sdi_d       = sdi_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        OP_START: begin
                            if (!csb_q) begin
                                state_d     = RESP;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = 8'h00;
                            end else begin
                                csb_d       = 1'b0;
                                phase_cnt_d = SETUP_RELOAD;
                                state_d     = CS_SETUP_W;
                            end
                        end
                        OP_END: begin
                            if (csb_q) begin
                                state_d     = RESP;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = 8'h00;
                            end else begin
                                sck_d       = 1'b0;
                                phase_cnt_d = SETUP_RELOAD;
                                state_d     = CS_HOLD_W;
                            end
                        end
                        default: begin
                            if (csb_q) begin
                                state_d     = RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = 8'h00;
                            end else begin
                                shift_d     = cmd_data;
                                sdi_d       = cmd_data[7];
                                sck_d       = 1'b0;
                                bit_cnt_d   = 3'd7;
                                phase_cnt_d = DIV_RELOAD;
                                op_d        = cmd_op;
                                state_d     = SHIFT_LO;
                            end
                        end
                    endcase
                end
            end
            CS_SETUP_W: begin
                if (phase_cnt_q == 8'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                end else begin
                    phase_cnt_d = phase_cnt_q - 8'd1;
                end
            end
            SHIFT_LO: begin
                if (phase_cnt_q == 8'd0) begin
                    sck_d       = 1'b1;
                    shift_d     = {shift_q[6:0], sdo_sync};
                    phase_cnt_d = DIV_RELOAD;
                    state_d     = SHIFT_HI;
                end else begin
                    phase_cnt_d = phase_cnt_q - 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_cnt_q == 8'd0) begin
                    sck_d     = 1'b0;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = (op_q == OP_XFER) ? shift_q : 8'h00;
                    end else begin
                        sdi_d       = shift_q[7];
                        phase_cnt_d = DIV_RELOAD;
                        state_d     = SHIFT_LO;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - 8'd1;
                end
            end
            CS_HOLD_W: begin
                if (phase_cnt_q == 8'd0) begin
                    csb_d       = 1'b1;
                    sdi_d       = 1'b0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                end else begin
                    phase_cnt_d = phase_cnt_q - 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_cnt_q <= 8'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            op_q        <= OP_START;
            sck_q       <= 1'b0;
            csb_q       <= 1'b1;
            sdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            op_q        <= op_d;
            sck_q       <= sck_d;
            csb_q       <= csb_d;
            sdi_q       <= sdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign cs_active = ~csb_q;
    assign spi_sck   = sck_q;
    assign spi_csb   = csb_q;
    assign spi_sdi   = sdi_q;

endmodule

// File: tb/tb_hkspi_host.sv
// tb_hkspi_host
// Directed bench for hkspi_host with a behavioural housekeeping SPI slave
// (read stream plus flash pass-thru) attached to the pins.
module tb_hkspi_host;

    import hkspi_host_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = OP_START;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       cs_active;
    logic       spi_sck;
    logic       spi_csb;
    logic       spi_sdi;
    logic       spi_sdo = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [255:0] sck_tr;
    logic [255:0] sdi_tr;
    logic [255:0] csb_tr;

    hkspi_host #(.CLK_DIV(4), .CS_SETUP(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .cs_active (cs_active),
        .spi_sck   (spi_sck),
        .spi_csb   (spi_csb),
        .spi_sdi   (spi_sdi),
        .spi_sdo   (spi_sdo)
    );

    always #5 clock = ~clock;

    // Behavioural slave: samples SDI on SCK rise, shifts SDO on SCK fall.
    logic [7:0]  flash_mem [0:7];
    logic        csb_prev = 1'b1;
    logic        sck_prev = 1'b0;
    logic [7:0]  rx_sh = 8'h00;
    logic [7:0]  tx_sh = 8'h00;
    logic [7:0]  mode_byte = 8'h00;
    logic [7:0]  hk_addr = 8'h00;
    logic [23:0] f_addr = 24'h0;
    int          bit_n = 0;
    int          byte_n = 0;
    int          rise_cnt = 0;

    always @(spi_sck or spi_csb) begin
        if (spi_csb !== csb_prev) begin
            csb_prev = spi_csb;
            if (spi_csb === 1'b0) begin
                bit_n     = 0;
                byte_n    = 0;
                rise_cnt  = 0;
                rx_sh     = 8'h00;
                tx_sh     = 8'h00;
                mode_byte = 8'h00;
                hk_addr   = 8'h00;
                f_addr    = 24'h0;
                spi_sdo   = 1'b0;
            end
        end
        if (spi_sck !== sck_prev) begin
            sck_prev = spi_sck;
            if (spi_csb === 1'b0) begin
                if (spi_sck === 1'b1) begin
                    rise_cnt++;
                    rx_sh = {rx_sh[6:0], spi_sdi};
                    bit_n++;
                    if (bit_n == 8) begin
                        bit_n = 0;
                        tx_sh = 8'h00;
                        if (byte_n == 0) begin
                            mode_byte = rx_sh;
                        end else if (mode_byte == HK_RD_STREAM) begin
                            if (byte_n == 1) hk_addr = rx_sh;
                            tx_sh = (hk_addr == 8'h03) ? 8'h10 : 8'h00;
                            hk_addr++;
                        end else if (mode_byte == HK_PASSTHRU && byte_n >= 2) begin
                            if (byte_n <= 4) f_addr = {f_addr[15:0], rx_sh};
                            if (byte_n >= 4) begin
                                tx_sh = flash_mem[f_addr[2:0]];
                                f_addr++;
                            end
                        end
                        byte_n++;
                    end
                end else begin
                    spi_sdo = tx_sh[7];
                    tx_sh   = {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one command, records pins per cycle after acceptance (index 1 is
    // the first cycle after the accepting edge) and returns the response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           output logic [7:0] rdata, output logic rerr,
                           output int lat);
        int w;
        w = 0;
        while (!cmd_ready && w < 300) begin
            step();
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        sck_tr = '0;
        sdi_tr = '0;
        csb_tr = '0;
        sdi_tr[0] = spi_sdi;
        lat = 1;
        while (!rsp_valid && lat < 250) begin
            sck_tr[lat] = spi_sck;
            sdi_tr[lat] = spi_sdi;
            csb_tr[lat] = spi_csb;
            step();
            lat++;
        end
        sck_tr[lat] = spi_sck;
        sdi_tr[lat] = spi_sdi;
        csb_tr[lat] = spi_csb;
        rdata = rsp_data;
        rerr  = rsp_err;
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL cmd_done op=%0d: rsp_valid=%b after %0d cycles, required 1", op, rsp_valid, lat);
        end
    endtask

    task automatic test_reset_values();
        logic [15:0] got;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        got = {spi_csb, spi_sck, spi_sdi, cmd_ready, rsp_valid, rsp_err, busy, cs_active, rsp_data};
        tests++;
        if (got !== 16'b1001_0000_0000_0000) begin
            fails++;
            $display("[TB] FAIL reset_values: got %b, required %b", got, 16'b1001_0000_0000_0000);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] d;
        logic e;
        int l;
        run_cmd(OP_WRITE, 8'hFF, d, e, l);
        tests++;
        if ({l, e, d} !== {32'd1, 1'b1, 8'h00}) begin
            fails++;
            $display("[TB] FAIL illegal_write: lat=%0d err=%b data=%h, required lat=1 err=1 data=00", l, e, d);
        end
        tests++;
        if ({csb_tr[1], sck_tr[1], sdi_tr[1]} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL illegal_write_pins: csb/sck/sdi=%b, required 100", {csb_tr[1], sck_tr[1], sdi_tr[1]});
        end
        run_cmd(OP_END, 8'h00, d, e, l);
        tests++;
        if ({l, e, csb_tr[1]} !== {32'd1, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL end_noop: lat=%0d err=%b csb=%b, required lat=1 err=0 csb=1", l, e, csb_tr[1]);
        end
    endtask

    task automatic test_product_id();
        logic [7:0] d;
        logic e;
        int l;
        run_cmd(OP_START, 8'h00, d, e, l);
        tests++;
        if ({l, csb_tr[1], cs_active} !== {32'd3, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL start_setup: lat=%0d csb=%b cs_active=%b, required lat=3 csb=0 cs_active=1", l, csb_tr[1], cs_active);
        end
        run_cmd(OP_WRITE, HK_RD_STREAM, d, e, l);
        run_cmd(OP_WRITE, 8'h03, d, e, l);
        run_cmd(OP_XFER, 8'h00, d, e, l);
        tests++;
        if ({e, d} !== {1'b0, 8'h10}) begin
            fails++;
            $display("[TB] FAIL product_id: err=%b data=%h, required err=0 data=10", e, d);
        end
        run_cmd(OP_END, 8'h00, d, e, l);
        tests++;
        if ({l, csb_tr[3:1], d} !== {32'd3, 3'b100, 8'h00}) begin
            fails++;
            $display("[TB] FAIL end_hold: lat=%0d csb=%b data=%h, required lat=3 csb=100 data=00", l, csb_tr[3:1], d);
        end
        tests++;
        if (rise_cnt != 24) begin
            fails++;
            $display("[TB] FAIL sck_rises: got %0d, required 24", rise_cnt);
        end
    endtask

    task automatic test_timing();
        logic [7:0] d;
        logic e;
        int l;
        int k;
        logic [127:0] exp_sck;
        logic [7:0] sdi_at_rise;
        logic [7:0] sdi_before_rise;
        run_cmd(OP_START, 8'h00, d, e, l);
        run_cmd(OP_WRITE, 8'hA5, d, e, l);
        tests++;
        if ({l, e, d} !== {32'd65, 1'b0, 8'h00}) begin
            fails++;
            $display("[TB] FAIL write_latency: lat=%0d err=%b data=%h, required lat=65 err=0 data=00", l, e, d);
        end
        exp_sck = '0;
        for (int n = 1; n <= 64; n++) exp_sck[n] = (((n - 1) / 4) % 2) == 1;
        tests++;
        if (sck_tr[65:0] !== exp_sck[65:0]) begin
            fails++;
            $display("[TB] FAIL sck_phases: got %h, required %h", sck_tr[65:0], exp_sck[65:0]);
        end
        // Rising edges fall on cycles 5, 13, ..., 61.
        sdi_at_rise = 8'h00;
        sdi_before_rise = 8'h00;
        for (int b = 0; b < 8; b++) begin
            k = 5 + 8 * b;
            sdi_at_rise     = {sdi_at_rise[6:0], sdi_tr[k]};
            sdi_before_rise = {sdi_before_rise[6:0], sdi_tr[k - 1]};
        end
        tests++;
        if ({sdi_before_rise, sdi_at_rise} !== 16'hA5A5) begin
            fails++;
            $display("[TB] FAIL sdi_bits: before=%h at=%h, required a5 a5", sdi_before_rise, sdi_at_rise);
        end
        run_cmd(OP_START, 8'h00, d, e, l);
        tests++;
        if ({l, e, csb_tr[1]} !== {32'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL start_twice: lat=%0d err=%b csb=%b, required lat=1 err=0 csb=0", l, e, csb_tr[1]);
        end
        run_cmd(OP_END, 8'h00, d, e, l);
    endtask

    task automatic test_passthru();
        logic [7:0] d;
        logic e;
        int l;
        logic [7:0] exp_bytes [0:7];
        exp_bytes = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
        run_cmd(OP_START, 8'h00, d, e, l);
        run_cmd(OP_WRITE, HK_PASSTHRU, d, e, l);
        run_cmd(OP_WRITE, 8'h03, d, e, l);
        run_cmd(OP_WRITE, 8'h00, d, e, l);
        run_cmd(OP_WRITE, 8'h00, d, e, l);
        run_cmd(OP_WRITE, 8'h00, d, e, l);
        for (int i = 0; i < 8; i++) begin
            run_cmd(OP_XFER, 8'h00, d, e, l);
            tests++;
            if ({e, d} !== {1'b0, exp_bytes[i]}) begin
                fails++;
                $display("[TB] FAIL passthru_byte%0d: err=%b data=%h, required err=0 data=%h", i, e, d, exp_bytes[i]);
            end
        end
        run_cmd(OP_END, 8'h00, d, e, l);
        tests++;
        if ({csb_tr[3:1], sck_tr[3:1]} !== 6'b100_000) begin
            fails++;
            $display("[TB] FAIL passthru_end: csb=%b sck=%b, required csb=100 sck=000", csb_tr[3:1], sck_tr[3:1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic e;
        int l;
        int w;
        int hs;
        int hs_n;
        int rsp_cnt;
        int first_rsp;
        int second_rsp;
        logic [7:0] second_data;
        run_cmd(OP_START, 8'h00, d, e, l);
        w = 0;
        while (!cmd_ready && w < 300) begin
            step();
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = 8'h3C;
        step();
        cmd_op   = OP_XFER;
        cmd_data = 8'h00;
        hs = 0; hs_n = 0; rsp_cnt = 0; first_rsp = 0; second_rsp = 0;
        second_data = 8'hFF;
        for (int n = 1; n <= 160; n++) begin
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cnt == 1) first_rsp = n;
                else begin
                    second_rsp  = n;
                    second_data = rsp_data;
                end
            end
            if (cmd_valid && cmd_ready) begin
                hs++;
                hs_n = n;
                step();
                cmd_valid = 1'b0;
            end else begin
                step();
            end
        end
        cmd_valid = 1'b0;
        tests++;
        if ({hs, hs_n} !== {32'd1, 32'd66}) begin
            fails++;
            $display("[TB] FAIL backpressure_accept: handshakes=%0d at %0d, required 1 at 66", hs, hs_n);
        end
        tests++;
        if ({rsp_cnt, first_rsp, second_rsp} !== {32'd2, 32'd65, 32'd131}) begin
            fails++;
            $display("[TB] FAIL backpressure_rsp: count=%0d first=%0d second=%0d, required 2 65 131", rsp_cnt, first_rsp, second_rsp);
        end
        tests++;
        if (second_data !== 8'h00) begin
            fails++;
            $display("[TB] FAIL backpressure_data: got %h, required 00", second_data);
        end
        run_cmd(OP_END, 8'h00, d, e, l);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic e;
        int l;
        int w;
        logic rv_seen;
        run_cmd(OP_START, 8'h00, d, e, l);
        w = 0;
        while (!cmd_ready && w < 300) begin
            step();
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_XFER;
        cmd_data  = 8'h5A;
        step();
        cmd_valid = 1'b0;
        repeat (20) step();
        tests++;
        if ({busy, spi_csb} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL xfer_active: busy/csb=%b, required 10", {busy, spi_csb});
        end
        reset = 1'b1;
        step();
        tests++;
        if ({spi_csb, spi_sck, busy, rsp_valid} !== 4'b1000) begin
            fails++;
            $display("[TB] FAIL reset_abort: csb/sck/busy/rsp_valid=%b, required 1000", {spi_csb, spi_sck, busy, rsp_valid});
        end
        rv_seen = 1'b0;
        repeat (4) begin
            step();
            if (rsp_valid !== 1'b0) rv_seen = 1'b1;
        end
        reset = 1'b0;
        step();
        tests++;
        if ({cmd_ready, spi_csb, cs_active} !== 3'b110) begin
            fails++;
            $display("[TB] FAIL reset_release: ready/csb/cs_active=%b, required 110", {cmd_ready, spi_csb, cs_active});
        end
        repeat (80) begin
            step();
            if (rsp_valid !== 1'b0) rv_seen = 1'b1;
        end
        tests++;
        if (rv_seen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_no_rsp: rsp_valid seen=%b, required 0", rv_seen);
        end
    endtask

    initial begin
        flash_mem = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
        test_reset_values();
        test_illegal();
        test_product_id();
        test_timing();
        test_passthru();
        test_back_to_back();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
